// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and writeback completion pulse.
// Optional macro RF_BYPASS_EN forwards same-cycle writes (and busy updates) to reads.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [NR*AW-1:0]      rd_addr,
  output logic [NR*XLEN-1:0]    rd_data,
  output logic [NR-1:0]         rd_busy,
  output logic                  rd_vld,
  input  logic [NW-1:0]         wr_en,
  input  logic [NW*AW-1:0]      wr_addr,
  input  logic [NW*XLEN-1:0]    wr_data,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  input  logic                  wb_valid,
  output logic                  wb_done,
  output logic [NREGS*XLEN-1:0] dbg_regs
);

  logic [XLEN-1:0]   regs      [NREGS];
  logic [XLEN-1:0]   regs_next [NREGS];
  logic [XLEN-1:0]   rd_src    [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [NREGS-1:0]  busy_src;
  logic [NR*XLEN-1:0] rd_data_next;
  logic [NR-1:0]      rd_busy_next;

  // Ports are scanned in ascending order so the highest-index writer wins;
  // sb_set is applied last so a newly issued producer keeps the register busy.
  // Out-of-range addresses never match a register and are therefore ignored.
  always_comb begin
    regs_next = regs;
    busy_next = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (!(ZERO_REG != 0 && r == 0)) begin
        for (int w = 0; w < NW; w++) begin
          if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == r) begin
            regs_next[r] = wr_data[w*XLEN +: XLEN];
            busy_next[r] = 1'b0;
          end
        end
        if (sb_set && int'(sb_addr) == r) begin
          busy_next[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef RF_BYPASS_EN
    rd_src   = regs_next;
    busy_src = busy_next;
`else
    rd_src   = regs;
    busy_src = busy;
`endif
  end

  always_comb begin
    rd_data_next = '0;
    rd_busy_next = '0;
    for (int p = 0; p < NR; p++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (int'(rd_addr[p*AW +: AW]) == r) begin
          rd_data_next[p*XLEN +: XLEN] = rd_src[r];
          rd_busy_next[p]              = busy_src[r];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy    <= '0;
      rd_data <= '0;
      rd_busy <= '0;
      rd_vld  <= 1'b0;
      wb_done <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= regs_next[r];
      end
      busy    <= busy_next;
      rd_vld  <= rd_req;
      wb_done <= wb_valid;
      if (rd_req) begin
        rd_data <= rd_data_next;
        rd_busy <= rd_busy_next;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_dbg
    assign dbg_regs[g*XLEN +: XLEN] = regs[g];
  end

endmodule
